// File: rtl/alu_ctrl_issue_pkg.sv
// alu_ctrl_issue_pkg: select codes and decoded payload shared by the ALU control path.
package alu_ctrl_issue_pkg;
    localparam logic [1:0] UNIT_ADD   = 2'd0;
    localparam logic [1:0] UNIT_LOGIC = 2'd1;
    localparam logic [1:0] UNIT_SHIFT = 2'd2;
    localparam logic [1:0] UNIT_CMP   = 2'd3;
    localparam logic [1:0] LOGIC_AND  = 2'd0;
    localparam logic [1:0] LOGIC_XOR  = 2'd1;
    localparam logic [1:0] LOGIC_OR   = 2'd2;
    localparam logic [1:0] SHIFT_SLL  = 2'd0;
    localparam logic [1:0] SHIFT_SRL  = 2'd1;
    localparam logic [1:0] SHIFT_SRA  = 2'd2;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    typedef struct packed {
        logic [1:0] unit_sel;
        logic [1:0] logic_opt;
        logic       add_sub;
        logic [1:0] shift_op;
        logic       cmp_uns;
        logic       word_op;
        logic       illegal;
    } dec_t;
endpackage

// File: rtl/alu_ctrl_issue_decode.sv
// alu_ctrl_issue_decode: combinational funct3/funct7 field decode into per-unit select codes.
module alu_ctrl_issue_decode
    import alu_ctrl_issue_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_is_imm,
    input  logic       i_is_word,
    output dec_t       o_dec
);
    logic w_word_ok;
    assign w_word_ok = (i_funct3 == F3_ADD) || (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);
    always_comb begin
        o_dec = '0;
        if (i_is_word && !w_word_ok) begin
            o_dec.illegal = 1'b1;
        end else begin
            o_dec.word_op = i_is_word;
            case (i_funct3)
                F3_ADD:  o_dec.add_sub = i_funct7_5 & ~i_is_imm;
                F3_SLL:  o_dec.unit_sel = UNIT_SHIFT;
                F3_SLT:  o_dec.unit_sel = UNIT_CMP;
                F3_SLTU: begin
                    o_dec.unit_sel = UNIT_CMP;
                    o_dec.cmp_uns  = 1'b1;
                end
                F3_XOR:  begin
                    o_dec.unit_sel  = UNIT_LOGIC;
                    o_dec.logic_opt = LOGIC_XOR;
                end
                F3_SR:   begin
                    o_dec.unit_sel = UNIT_SHIFT;
                    o_dec.shift_op = i_funct7_5 ? SHIFT_SRA : SHIFT_SRL;
                end
                F3_OR:   begin
                    o_dec.unit_sel  = UNIT_LOGIC;
                    o_dec.logic_opt = LOGIC_OR;
                end
                default: o_dec.unit_sel = UNIT_LOGIC;
            endcase
        end
    end
endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ALU ops on the IDU side and issues them to the EXU
// through a 2-entry valid/ready skid buffer with registered outputs.
module alu_ctrl_issue
    import alu_ctrl_issue_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_funct3,
    input  logic             i_funct7_5,
    input  logic             i_is_imm,
    input  logic             i_is_word,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [1:0]       o_unit_sel,
    output logic [1:0]       o_logic_opt,
    output logic             o_add_sub,
    output logic [1:0]       o_shift_op,
    output logic             o_cmp_uns,
    output logic             o_word_op,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_out_tag
);
    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
    state_t           r_state;
    dec_t             r_head, r_skid, w_dec;
    logic [TAG_W-1:0] r_head_tag, r_skid_tag;
    logic             w_push, w_pop;
    alu_ctrl_issue_decode u_decode (
        .i_funct3   (i_funct3),
        .i_funct7_5 (i_funct7_5),
        .i_is_imm   (i_is_imm),
        .i_is_word  (i_is_word),
        .o_dec      (w_dec)
    );
    // in_ready depends only on state and rst, never on out_ready
    assign o_in_ready  = (r_state != FULL) & ~rst;
    assign o_out_valid = (r_state != EMPTY);
    assign w_push      = i_in_valid & o_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_head     <= '0;
            r_skid     <= '0;
            r_head_tag <= '0;
            r_skid_tag <= '0;
        end else if (i_flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_push) begin
                    r_state    <= HALF;
                    r_head     <= w_dec;
                    r_head_tag <= i_in_tag;
                end
                HALF: if (w_push && !w_pop) begin
                    r_state    <= FULL;
                    r_skid     <= w_dec;
                    r_skid_tag <= i_in_tag;
                end else if (w_pop && !w_push) begin
                    r_state <= EMPTY;
                end else if (w_push) begin
                    r_head     <= w_dec;
                    r_head_tag <= i_in_tag;
                end
                FULL: if (w_pop) begin
                    r_state    <= HALF;
                    r_head     <= r_skid;
                    r_head_tag <= r_skid_tag;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end
    assign o_unit_sel  = r_head.unit_sel;
    assign o_logic_opt = r_head.logic_opt;
    assign o_add_sub   = r_head.add_sub;
    assign o_shift_op  = r_head.shift_op;
    assign o_cmp_uns   = r_head.cmp_uns;
    assign o_word_op   = r_head.word_op;
    assign o_illegal   = r_head.illegal;
    assign o_out_tag   = r_head_tag;
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: decode vector table, skid/flush/reset sequences and a randomized
// scoreboard run against a queue-based reference of the issue buffer.
module tb_alu_ctrl_issue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, is_imm = 1'b0, is_word = 1'b0;
    logic [4:0] in_tag = '0;
    logic       in_ready, out_valid, add_sub, cmp_uns, word_op, illegal;
    logic [1:0] unit_sel, logic_opt, shift_op;
    logic [4:0] out_tag;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_issue #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_funct3(funct3), .i_funct7_5(funct7_5), .i_is_imm(is_imm), .i_is_word(is_word),
        .i_in_tag(in_tag), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_unit_sel(unit_sel), .o_logic_opt(logic_opt), .o_add_sub(add_sub),
        .o_shift_op(shift_op), .o_cmp_uns(cmp_uns), .o_word_op(word_op),
        .o_illegal(illegal), .o_out_tag(out_tag)
    );

    // payload layout: unit, logic_opt, add_sub, shift_op, cmp_uns, word_op, illegal, tag
    logic [14:0] act_pl;
    assign act_pl = {unit_sel, logic_opt, add_sub, shift_op, cmp_uns, word_op, illegal, out_tag};

    typedef struct {
        logic [2:0] f3;
        logic       f75, imm, word;
        logic [4:0] tag;
        logic [1:0] unit, lopt;
        logic       add;
        logic [1:0] sh;
        logic       cmpu, wop, ill;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] f3, input logic f75, input logic imm,
                          input logic word, input logic [4:0] tag);
        funct3 = f3; funct7_5 = f75; is_imm = imm; is_word = word; in_tag = tag;
    endtask

    function automatic logic [14:0] ref_pl(input logic [2:0] f3, input logic f75,
                                           input logic imm, input logic word, input logic [4:0] tag);
        logic [1:0] unit, lopt, sh;
        if (word && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5))
            return {2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, tag};
        unit = (f3 == 3'd0) ? 2'd0 : (f3 == 3'd1 || f3 == 3'd5) ? 2'd2 :
               (f3 == 3'd2 || f3 == 3'd3) ? 2'd3 : 2'd1;
        lopt = (f3 == 3'd4) ? 2'd1 : (f3 == 3'd6) ? 2'd2 : 2'd0;
        sh   = (f3 == 3'd5) ? (f75 ? 2'd2 : 2'd1) : 2'd0;
        return {unit, lopt, f3 == 3'd0 && f75 && !imm, sh, f3 == 3'd3, word, 1'b0, tag};
    endfunction

    logic [14:0] q[$];

    initial begin
        vecs = '{
            '{3'b111, 1'b0, 1'b0, 1'b0, 5'd5,  2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
            '{3'b100, 1'b0, 1'b0, 1'b0, 5'd6,  2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
            '{3'b110, 1'b0, 1'b0, 1'b0, 5'd7,  2'd1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
            '{3'b000, 1'b1, 1'b1, 1'b0, 5'd8,  2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
            '{3'b000, 1'b1, 1'b0, 1'b0, 5'd9,  2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0},
            '{3'b101, 1'b1, 1'b0, 1'b0, 5'd10, 2'd2, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0},
            '{3'b101, 1'b0, 1'b1, 1'b0, 5'd11, 2'd2, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
            '{3'b001, 1'b0, 1'b0, 1'b0, 5'd12, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
            '{3'b010, 1'b0, 1'b0, 1'b0, 5'd13, 2'd3, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
            '{3'b011, 1'b0, 1'b1, 1'b0, 5'd14, 2'd3, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0},
            '{3'b100, 1'b0, 1'b0, 1'b1, 5'd15, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1},
            '{3'b000, 1'b1, 1'b0, 1'b1, 5'd16, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0},
            '{3'b101, 1'b1, 1'b1, 1'b1, 5'd17, 2'd2, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0}
        };

        // reset: in_ready low while rst is asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_payload", act_pl, 0);

        // decode table, back-to-back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            set_op(vecs[i].f3, vecs[i].f75, vecs[i].imm, vecs[i].word, vecs[i].tag);
            tick();
            chk("vec_valid", out_valid, 1);
            chk("vec_payload", act_pl, {vecs[i].unit, vecs[i].lopt, vecs[i].add, vecs[i].sh,
                                        vecs[i].cmpu, vecs[i].wop, vecs[i].ill, vecs[i].tag});
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);

        // stall: fill both entries, head stays put until released
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_op(3'b111, 1'b0, 1'b0, 1'b0, 5'd1);
        tick();
        set_op(3'b011, 1'b0, 1'b0, 1'b0, 5'd2);
        tick();
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_head", act_pl, ref_pl(3'b111, 1'b0, 1'b0, 1'b0, 5'd1));
        tick();
        tick();
        chk("stall_stable", act_pl, ref_pl(3'b111, 1'b0, 1'b0, 1'b0, 5'd1));
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("second_head", act_pl, ref_pl(3'b011, 1'b0, 1'b0, 1'b0, 5'd2));
        chk("second_in_ready", in_ready, 1);
        tick();
        chk("drained", out_valid, 0);

        // flush in FULL with in_valid, then flush in HALF with an acceptable push
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_op(3'b000, 1'b0, 1'b0, 1'b0, 5'd20);
        tick();
        set_op(3'b000, 1'b0, 1'b0, 1'b0, 5'd21);
        tick();
        flush = 1'b1;
        set_op(3'b000, 1'b0, 1'b0, 1'b0, 5'd22);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", out_valid, 0);
        chk("flush_full_ready", in_ready, 1);
        in_valid = 1'b1;
        set_op(3'b110, 1'b0, 1'b0, 1'b0, 5'd23);
        tick();
        flush = 1'b1;
        set_op(3'b110, 1'b0, 1'b0, 1'b0, 5'd24);
        tick();
        flush = 1'b0;
        set_op(3'b100, 1'b0, 1'b0, 1'b0, 5'd25);
        tick();
        in_valid = 1'b0;
        chk("flush_half_next", act_pl, ref_pl(3'b100, 1'b0, 1'b0, 1'b0, 5'd25));
        out_ready = 1'b1;
        tick();
        chk("flush_half_drained", out_valid, 0);

        // reset mid-transfer clears payload
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_op(3'b101, 1'b1, 1'b0, 1'b1, 5'd31);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_payload", act_pl, 0);
        chk("midrst_ready_after", in_ready, 1);

        // randomized traffic against the queue model
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            logic do_push, do_pop;
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 49) == 0;
            set_op(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom));
            #1;
            chk("rnd_out_valid", out_valid, q.size() != 0);
            chk("rnd_in_ready", in_ready, q.size() < 2);
            if (q.size() != 0) chk("rnd_head", act_pl, q[0]);
            do_push = in_valid && q.size() < 2;
            do_pop  = out_ready && q.size() != 0;
            @(posedge clk);
            if (flush) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(ref_pl(funct3, funct7_5, is_imm, is_word, in_tag));
            end
            #1;
            if (q.size() > 2) chk("rnd_occupancy", q.size(), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
